// File: rtl/p_stack_seq.sv
// rtl/p_stack_seq.sv - 6502 stack sequencer for interrupt entry, RTI, PHP and PLP
// Drives the bus, PC/SP load strobes and the status mask/select port from the current state.
module p_stack_seq #(
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_int,
  input  logic [1:0]  int_kind,
  input  logic        start_rti,
  input  logic        start_php,
  input  logic        start_plp,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  sr,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic [15:0] pc_out,
  output logic        pc_we,
  output logic [7:0]  sp_out,
  output logic        sp_we,
  output logic [7:0]  sr_mask,
  output logic [1:0]  sr_sel,
  output logic [7:0]  sr_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE, E1, E2, E3, E4, E5, E6, R1, R2, R3, R4, H1, L1, L2
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  s_q;
  logic [15:0] pc_q;
  logic [1:0]  kind_q;
  logic [7:0]  low_q;
  logic        any_start;
  logic        is_brk, is_nmi;
  logic [7:0]  s_m1, s_m2, s_m3, s_p1, s_p2, s_p3;

  assign any_start = start_int | start_rti | start_php | start_plp;
  assign is_brk    = (kind_q == 2'b00);
  assign is_nmi    = (kind_q == 2'b10);
  assign s_m1      = s_q - 8'd1;
  assign s_m2      = s_q - 8'd2;
  assign s_m3      = s_q - 8'd3;
  assign s_p1      = s_q + 8'd1;
  assign s_p2      = s_q + 8'd2;
  assign s_p3      = s_q + 8'd3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      s_q    <= 8'h00;
      pc_q   <= 16'h0000;
      kind_q <= 2'b00;
      low_q  <= 8'h00;
    end else begin
      state <= state_nx;
      if (state == IDLE && any_start) begin
        s_q    <= sp_in;
        pc_q   <= pc_in;
        kind_q <= int_kind;
      end
      // Vector low byte (E5) and pulled PCL (R3) arrive one cycle after their read
      if (state == E5 || state == R3)
        low_q <= mem_rdata;
    end
  end

  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE: begin
        if (start_int)      state_nx = E1;
        else if (start_rti) state_nx = R1;
        else if (start_plp) state_nx = L1;
        else if (start_php) state_nx = H1;
        else                state_nx = IDLE;
      end
      E1:      state_nx = E2;
      E2:      state_nx = E3;
      E3:      state_nx = E4;
      E4:      state_nx = E5;
      E5:      state_nx = E6;
      R1:      state_nx = R2;
      R2:      state_nx = R3;
      R3:      state_nx = R4;
      L1:      state_nx = L2;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    pc_out    = 16'h0000;
    pc_we     = 1'b0;
    sp_out    = 8'h00;
    sp_we     = 1'b0;
    sr_mask   = 8'h00;
    sr_sel    = 2'd0;
    sr_data   = 8'h00;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      E1: begin
        mem_addr  = {STACK_PAGE, s_q};
        mem_wdata = pc_q[15:8];
        mem_we    = 1'b1;
      end
      E2: begin
        mem_addr  = {STACK_PAGE, s_m1};
        mem_wdata = pc_q[7:0];
        mem_we    = 1'b1;
      end
      E3: begin
        // Pushed P reflects sr before I is set; B distinguishes BRK from hardware interrupts
        mem_addr  = {STACK_PAGE, s_m2};
        mem_wdata = {sr[7:6], 1'b1, is_brk, sr[3:0]};
        mem_we    = 1'b1;
        sr_mask   = 8'h04;
        sr_sel    = 2'd1;
      end
      E4: begin
        mem_addr = is_nmi ? 16'hFFFA : 16'hFFFE;
        mem_re   = 1'b1;
      end
      E5: begin
        mem_addr = is_nmi ? 16'hFFFB : 16'hFFFF;
        mem_re   = 1'b1;
      end
      E6: begin
        pc_out = {mem_rdata, low_q};
        pc_we  = 1'b1;
        sp_out = s_m3;
        sp_we  = 1'b1;
        done   = 1'b1;
      end
      R1: begin
        mem_addr = {STACK_PAGE, s_p1};
        mem_re   = 1'b1;
      end
      R2: begin
        mem_addr = {STACK_PAGE, s_p2};
        mem_re   = 1'b1;
        sr_mask  = 8'hCF;
        sr_sel   = 2'd2;
        sr_data  = mem_rdata;
      end
      R3: begin
        mem_addr = {STACK_PAGE, s_p3};
        mem_re   = 1'b1;
      end
      R4: begin
        pc_out = {mem_rdata, low_q};
        pc_we  = 1'b1;
        sp_out = s_p3;
        sp_we  = 1'b1;
        done   = 1'b1;
      end
      H1: begin
        mem_addr  = {STACK_PAGE, s_q};
        mem_wdata = sr | 8'h30;
        mem_we    = 1'b1;
        sp_out    = s_m1;
        sp_we     = 1'b1;
        done      = 1'b1;
      end
      L1: begin
        mem_addr = {STACK_PAGE, s_p1};
        mem_re   = 1'b1;
      end
      L2: begin
        sr_mask = 8'hCF;
        sr_sel  = 2'd2;
        sr_data = mem_rdata;
        sp_out  = s_p1;
        sp_we   = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_p_stack_seq.sv
// tb/tb_p_stack_seq.sv - scoreboard bench for p_stack_seq
// Stimulus pushes per-cycle expected output vectors; a negedge monitor pops one per busy cycle.
module tb_p_stack_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_int, start_rti, start_php, start_plp;
  logic [1:0]  int_kind;
  logic [15:0] pc_in;
  logic [7:0]  sp_in, sr, mem_rdata;
  logic [15:0] mem_addr, pc_out;
  logic [7:0]  mem_wdata, sp_out, sr_mask, sr_data;
  logic        mem_we, mem_re, pc_we, sp_we, busy, done;
  logic [1:0]  sr_sel;

  logic [7:0]  mem [0:65535];
  logic [70:0] exp_q [$];
  string       name_q [$];
  int          checks = 0;
  int          errors = 0;

  p_stack_seq dut (
    .clk(clk), .rst_n(rst_n), .start_int(start_int), .int_kind(int_kind),
    .start_rti(start_rti), .start_php(start_php), .start_plp(start_plp),
    .pc_in(pc_in), .sp_in(sp_in), .sr(sr), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .pc_out(pc_out), .pc_we(pc_we), .sp_out(sp_out), .sp_we(sp_we),
    .sr_mask(sr_mask), .sr_sel(sr_sel), .sr_data(sr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  wire [70:0] act = {mem_addr, mem_wdata, mem_we, mem_re, pc_out, pc_we,
                     sp_out, sp_we, sr_mask, sr_sel, sr_data, done};

  // Bus model: read data valid the cycle after mem_re
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string nm, input logic [70:0] a, input logic [70:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && busy === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_busy_cycle actual=%h required=idle", act);
      end else begin
        chk(name_q.pop_front(), act, exp_q.pop_front());
      end
    end
  end

  function automatic logic [70:0] v(input logic [15:0] a, input logic [7:0] wd,
      input logic we, input logic re, input logic [15:0] pc, input logic pcwe,
      input logic [7:0] sp, input logic spwe, input logic [7:0] m,
      input logic [1:0] sel, input logic [7:0] d, input logic dn);
    return {a, wd, we, re, pc, pcwe, sp, spwe, m, sel, d, dn};
  endfunction

  task automatic push(input string nm, input logic [70:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic wr(input string nm, input logic [15:0] a, input logic [7:0] d);
    push(nm, v(a, d, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic rd(input string nm, input logic [15:0] a);
    push(nm, v(a, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic go(input logic i, input logic r, input logic p, input logic l,
      input logic [1:0] k, input logic [15:0] pc, input logic [7:0] sp, input logic [7:0] s);
    @(negedge clk);
    start_int = i; start_rti = r; start_php = p; start_plp = l;
    int_kind = k; pc_in = pc; sp_in = sp; sr = s;
    @(negedge clk);
    start_int = 0; start_rti = 0; start_php = 0; start_plp = 0;
    int_kind = 2'b01; pc_in = 16'hFFFF; sp_in = 8'h55;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 30 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout actual=busy:%b pending:%0d required=idle", nm, busy, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic chk_mem(input string nm, input logic [15:0] a, input logic [7:0] e);
    checks++;
    if (mem[a] !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, mem[a], e);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem_rdata = 8'h00;
    rst_n = 0;
    start_int = 0; start_rti = 0; start_php = 0; start_plp = 0;
    int_kind = 0; pc_in = 0; sp_in = 0; sr = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", act, 71'd0);
    chk("reset_busy", {70'd0, busy}, 71'd0);
    rst_n = 1;

    // IRQ entry
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h80;
    wr("irq_e1", 16'h01FD, 8'hC1);
    wr("irq_e2", 16'h01FC, 8'h23);
    push("irq_e3", v(16'h01FB, 8'h24, 1, 0, 0, 0, 0, 0, 8'h04, 2'd1, 0, 0));
    rd("irq_e4", 16'hFFFE);
    rd("irq_e5", 16'hFFFF);
    push("irq_e6", v(0, 0, 0, 0, 16'h8000, 1, 8'hFA, 1, 0, 0, 0, 1));
    go(1, 0, 0, 0, 2'b01, 16'hC123, 8'hFD, 8'h24);
    wait_idle("irq");
    chk_mem("irq_mem_01fd", 16'h01FD, 8'hC1);
    chk_mem("irq_mem_01fb", 16'h01FB, 8'h24);

    // BRK with stack wrap
    mem[16'hFFFE] = 8'h34; mem[16'hFFFF] = 8'h12;
    wr("brk_e1", 16'h0101, 8'h45);
    wr("brk_e2", 16'h0100, 8'h67);
    push("brk_e3", v(16'h01FF, 8'h30, 1, 0, 0, 0, 0, 0, 8'h04, 2'd1, 0, 0));
    rd("brk_e4", 16'hFFFE);
    rd("brk_e5", 16'hFFFF);
    push("brk_e6", v(0, 0, 0, 0, 16'h1234, 1, 8'hFE, 1, 0, 0, 0, 1));
    go(1, 0, 0, 0, 2'b00, 16'h4567, 8'h01, 8'h20);
    wait_idle("brk");
    chk_mem("brk_mem_01ff", 16'h01FF, 8'h30);

    // NMI with D set: D must not appear in the mask
    mem[16'hFFFA] = 8'hCD; mem[16'hFFFB] = 8'hEF;
    wr("nmi_e1", 16'h0180, 8'hAB);
    wr("nmi_e2", 16'h017F, 8'hCD);
    push("nmi_e3", v(16'h017E, 8'h28, 1, 0, 0, 0, 0, 0, 8'h04, 2'd1, 0, 0));
    rd("nmi_e4", 16'hFFFA);
    rd("nmi_e5", 16'hFFFB);
    push("nmi_e6", v(0, 0, 0, 0, 16'hEFCD, 1, 8'h7D, 1, 0, 0, 0, 1));
    go(1, 0, 0, 0, 2'b10, 16'hABCD, 8'h80, 8'h08);
    wait_idle("nmi");

    // RTI
    mem[16'h01FB] = 8'hFF; mem[16'h01FC] = 8'h34; mem[16'h01FD] = 8'h12;
    rd("rti_r1", 16'h01FB);
    push("rti_r2", v(16'h01FC, 0, 0, 1, 0, 0, 0, 0, 8'hCF, 2'd2, 8'hFF, 0));
    rd("rti_r3", 16'h01FD);
    push("rti_r4", v(0, 0, 0, 0, 16'h1234, 1, 8'hFD, 1, 0, 0, 0, 1));
    go(0, 1, 0, 0, 2'b00, 16'h0000, 8'hFA, 8'h00);
    wait_idle("rti");

    // PHP then PLP with wrap
    push("php_h1", v(16'h01FF, 8'hB1, 1, 0, 0, 0, 8'hFE, 1, 0, 0, 0, 1));
    go(0, 0, 1, 0, 2'b00, 16'h0000, 8'hFF, 8'h81);
    wait_idle("php");
    chk_mem("php_mem_01ff", 16'h01FF, 8'hB1);
    mem[16'h0100] = 8'h5A;
    rd("plp_l1", 16'h0100);
    push("plp_l2", v(0, 0, 0, 0, 0, 0, 8'h00, 1, 8'hCF, 2'd2, 8'h5A, 1));
    go(0, 0, 0, 1, 2'b00, 16'h0000, 8'hFF, 8'h00);
    wait_idle("plp");

    // Simultaneous starts, kind 11 as IRQ, start_php pulsed while busy
    wr("sim_e1", 16'h01F0, 8'h20);
    wr("sim_e2", 16'h01EF, 8'h00);
    push("sim_e3", v(16'h01EE, 8'h24, 1, 0, 0, 0, 0, 0, 8'h04, 2'd1, 0, 0));
    rd("sim_e4", 16'hFFFE);
    rd("sim_e5", 16'hFFFF);
    push("sim_e6", v(0, 0, 0, 0, 16'h1234, 1, 8'hED, 1, 0, 0, 0, 1));
    go(1, 1, 1, 0, 2'b11, 16'h2000, 8'hF0, 8'h04);
    @(negedge clk); start_php = 1; start_rti = 1;
    repeat (2) @(negedge clk);
    start_php = 0; start_rti = 0;
    wait_idle("sim");

    // Reset asserted during E2
    wr("rst_e1", 16'h0190, 8'h55);
    wr("rst_e2", 16'h018F, 8'h55);
    go(1, 0, 0, 0, 2'b01, 16'h5555, 8'h90, 8'h00);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_outputs", act, 71'd0);
    chk("midrst_busy", {70'd0, busy}, 71'd0);
    @(negedge clk);
    rst_n = 1;
    chk_mem("midrst_partial_push", 16'h0190, 8'h55);
    chk_mem("midrst_no_second_push", 16'h018F, 8'h00);
    push("post_php_h1", v(16'h0150, 8'h30, 1, 0, 0, 0, 8'h4F, 1, 0, 0, 0, 1));
    go(0, 0, 1, 0, 2'b00, 16'h0000, 8'h50, 8'h00);
    wait_idle("post_php");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
